reg_bus_regfile: RTL and testbench

- Register-bus slave that terminates the REG_BUS "in" side: accepts valid/ready requests and returns rdata/error.
- Contains four DATA_WIDTH-bit word registers: CTRL, SCRATCH, STATUS and IRQ.
- Exposes CTRL and a masked interrupt to surrounding hardware.
- Sits directly downstream of the bus master / crossbar in the peripheral subsystem.

---
 rtl/reg_bus_regfile.sv | 201 ++++++++++++++++++++
 tb/tb_reg_bus_regfile.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_regfile.sv
// Purpose: register-bus slave holding CTRL, SCRATCH, STATUS and IRQ words; drives ctrl_o and a masked irq_o.
// Latency: ready_o rises 1+WAIT_CYCLES cycles after valid_i rises; every output is registered.
// Backpressure: the master holds its request until ready_o; at most one transfer per 2+WAIT_CYCLES cycles.
// Build option: define REG_BUS_REGFILE_RO_ERR_EN to make writes to STATUS answer with an error.
module reg_bus_regfile #(
    parameter int unsigned           ADDR_WIDTH  = 2,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    write_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    valid_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    error_o,
    output logic                    ready_o,
    input  logic [DATA_WIDTH-1:0]   event_i,
    output logic [DATA_WIDTH-1:0]   ctrl_o,
    output logic                    irq_o
);

    localparam int              STRB_WIDTH = DATA_WIDTH / 8;
    localparam int              HALF       = DATA_WIDTH / 2;
    localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [HALF-1:0] ONE_H      = 1;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_SCRATCH = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_IRQ     = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    // High on the edge that accepts a request: the response is registered and writes land here.
    logic                  commit;

    logic [DATA_WIDTH-1:0] ctrl_q, scratch_q, irq_q;
    logic [HALF-1:0]       wcnt_q, ecnt_q;

    logic [1:0]            reg_sel;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] irq_clr;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  wr_counted;
    logic                  reg_wr;

    assign reg_sel = addr_i[1:0];

    // Only word addresses 0..3 exist; upper address bits must be zero.
    generate
        if (ADDR_WIDTH > 2) begin : g_wide_addr
            assign in_range = ~|addr_i[ADDR_WIDTH-1:2];
        end else begin : g_narrow_addr
            assign in_range = 1'b1;
        end
    endgenerate

    // State register and wait-state counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a dropped valid_i during wait states abandons the request silently
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!valid_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Expand byte strobes into a bit mask
    always_comb begin
        bmask = '0;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            bmask[8*k +: 8] = {8{wstrb_i[k]}};
        end
    end

    // Response decode: read data, error flag and whether this write counts as completed
    always_comb begin
        resp_rdata = '0;
        resp_err   = 1'b0;
        wr_counted = 1'b0;
        if (!in_range) begin
            resp_err = 1'b1;
        end else if (!write_i) begin
            case (reg_sel)
                A_CTRL:    resp_rdata = ctrl_q;
                A_SCRATCH: resp_rdata = scratch_q;
                A_STATUS:  resp_rdata = {wcnt_q, ecnt_q};
                A_IRQ:     resp_rdata = irq_q;
            endcase
        end else begin
            case (reg_sel)
                A_STATUS: begin
`ifdef REG_BUS_REGFILE_RO_ERR_EN
                    resp_err = 1'b1;
`else
                    resp_err = 1'b0;
`endif
                end
                default: wr_counted = |wstrb_i;
            endcase
        end
    end

    assign reg_wr  = commit && write_i && in_range;
    assign irq_clr = (reg_wr && reg_sel == A_IRQ) ? (wdata_i & bmask) : '0;

    // CTRL and SCRATCH byte-strobed writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= CTRL_RESET;
            scratch_q <= '0;
        end else if (reg_wr) begin
            case (reg_sel)
                A_CTRL:    ctrl_q    <= (ctrl_q & ~bmask) | (wdata_i & bmask);
                A_SCRATCH: scratch_q <= (scratch_q & ~bmask) | (wdata_i & bmask);
                default:   ;
            endcase
        end
    end

    // IRQ: events set bits, write-1 clears; a same-cycle event beats the clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= '0;
        end else begin
            irq_q <= (irq_q & ~irq_clr) | event_i;
        end
    end

    // STATUS counters, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
            ecnt_q <= '0;
        end else if (commit) begin
            if (wr_counted && wcnt_q != '1) wcnt_q <= wcnt_q + ONE_H;
            if (resp_err && ecnt_q != '1)   ecnt_q <= ecnt_q + ONE_H;
        end
    end

    // Registered bus response and interrupt output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_o <= 1'b0;
            error_o <= 1'b0;
            rdata_o <= '0;
            irq_o   <= 1'b0;
        end else begin
            ready_o <= commit;
            error_o <= commit & resp_err;
            rdata_o <= commit ? resp_rdata : '0;
            irq_o   <= |(irq_q & ctrl_q);
        end
    end

    assign ctrl_o = ctrl_q;

endmodule

// File: tb/tb_reg_bus_regfile.sv
`timescale 1ns/1ps
module tb_reg_bus_regfile;

    localparam int          AW  = 3;
    localparam int          W0  = 0;
    localparam int          W1  = 3;
    localparam logic [31:0] CR0 = 32'hC0DE_0000;
    localparam logic [31:0] CR1 = 32'h0000_0010;

    logic          clk = 1'b0;
    logic [1:0]    rst;
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [1:0]    vld;
    logic [31:0]   event_i;
    logic [31:0]   rdata [2];
    logic [31:0]   ctrl  [2];
    logic [1:0]    err, rdy, irq;

    always #5 clk = ~clk;

    reg_bus_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_CYCLES(W0), .CTRL_RESET(CR0)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .addr_i(addr), .write_i(write), .wdata_i(wdata),
        .wstrb_i(wstrb), .valid_i(vld[0]), .rdata_o(rdata[0]), .error_o(err[0]),
        .ready_o(rdy[0]), .event_i(event_i), .ctrl_o(ctrl[0]), .irq_o(irq[0]));

    reg_bus_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_CYCLES(W1), .CTRL_RESET(CR1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .addr_i(addr), .write_i(write), .wdata_i(wdata),
        .wstrb_i(wstrb), .valid_i(vld[1]), .rdata_o(rdata[1]), .error_o(err[1]),
        .ready_o(rdy[1]), .event_i(event_i), .ctrl_o(ctrl[1]), .irq_o(irq[1]));

    // Reference model: plain register contents and counters per device
    logic [31:0] m_ctrl [2];
    logic [31:0] m_scr  [2];
    logic [31:0] m_irq  [2];
    int          m_wcnt [2];
    int          m_ecnt [2];

    typedef struct {
        logic [31:0] rd;
        logic        er;
        logic        chk_rd;
        int          cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        m_ctrl[d] = (d == 0) ? CR0 : CR1;
        m_scr[d]  = '0;
        m_irq[d]  = '0;
        m_wcnt[d] = 0;
        m_ecnt[d] = 0;
    endtask

    task automatic model_txn(input int d, input logic wr, input logic [AW-1:0] a,
                             input logic [31:0] wd, input logic [3:0] st,
                             output logic [31:0] rd, output logic er);
        logic [31:0] m;
        logic        counted;
        m = '0;
        for (int k = 0; k < 4; k++) if (st[k]) m[8*k +: 8] = 8'hFF;
        rd = '0;
        er = 1'b0;
        counted = 1'b0;
        if (a > 3'd3) begin
            er = 1'b1;
        end else if (!wr) begin
            if (a == 3'd0)      rd = m_ctrl[d];
            else if (a == 3'd1) rd = m_scr[d];
            else if (a == 3'd2) rd = 32'(m_wcnt[d] * 65536 + m_ecnt[d]);
            else                rd = m_irq[d];
        end else if (a == 3'd2) begin
`ifdef REG_BUS_REGFILE_RO_ERR_EN
            er = 1'b1;
`endif
        end else begin
            counted = (st != 4'h0);
            if (a == 3'd0)      m_ctrl[d] = (m_ctrl[d] & ~m) | (wd & m);
            else if (a == 3'd1) m_scr[d]  = (m_scr[d] & ~m) | (wd & m);
            else                m_irq[d]  = m_irq[d] & ~(wd & m);
        end
        if (er && m_ecnt[d] < 65535) m_ecnt[d]++;
        if (counted && m_wcnt[d] < 65535) m_wcnt[d]++;
    endtask

    task automatic sb_push(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Monitor: pops an expectation on every ready_o, otherwise requires quiet outputs
    task automatic mon(input int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? sb0.size() : sb1.size();
        if (rdy[d] === 1'b1) begin
            if (sz == 0) begin
                check($sformatf("unexpected_ready_dut%0d", d), 32'(rdy[d]), 32'h0);
            end else begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check($sformatf("error_dut%0d", d), 32'(err[d]), 32'(e.er));
                check($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
                if (e.chk_rd) check($sformatf("rdata_dut%0d", d), rdata[d], e.rd);
            end
        end else begin
            check($sformatf("idle_outputs_dut%0d", d), rdata[d] | 32'(err[d]) | 32'(rdy[d]), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    task automatic wait_ready(input int d, output bit got);
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(posedge clk);
            #1;
            event_i = '0;
            if (rdy[d] === 1'b1) got = 1'b1;
        end
    endtask

    // Issue one request held for 'reps' back-to-back transfers; 'ev' pulses event_i in the
    // request's first cycle (only used with the zero-wait device, where that is the commit cycle)
    task automatic do_txn(input int d, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input int reps, input logic [31:0] ev);
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        int          w;
        int          n0;
        bit          got;
        w = (d == 0) ? W0 : W1;
        @(posedge clk);
        #1;
        addr = a; write = wr; wdata = wd; wstrb = st; event_i = ev;
        vld[d] = 1'b1;
        n0 = cyc;
        for (int k = 0; k < reps; k++) begin
            model_txn(d, wr, a, wd, st, rd, er);
            if (k == 0) begin
                m_irq[0] = m_irq[0] | ev;
                m_irq[1] = m_irq[1] | ev;
            end
            e.rd = rd; e.er = er; e.chk_rd = !wr;
            e.cyc = n0 + 1 + w + k * (2 + w);
            sb_push(d, e);
        end
        for (int k = 0; k < reps; k++) begin
            wait_ready(d, got);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL ready_timeout_dut%0d: ready_o stayed 0 for 40 cycles, expected 1", d);
                if (d == 0) sb0.delete();
                else        sb1.delete();
                break;
            end
        end
        vld[d] = 1'b0;
    endtask

    task automatic pulse_event(input logic [31:0] ev);
        @(posedge clk);
        #1;
        event_i = ev;
        @(posedge clk);
        #1;
        event_i = '0;
        m_irq[0] = m_irq[0] | ev;
        m_irq[1] = m_irq[1] | ev;
    endtask

    task automatic check_side(input int d);
        check($sformatf("ctrl_o_dut%0d", d), ctrl[d], m_ctrl[d]);
        check($sformatf("irq_o_dut%0d", d), 32'(irq[d]), 32'(|(m_irq[d] & m_ctrl[d])));
    endtask

    task automatic settle_side();
        @(posedge clk);
        #1;
        check_side(0);
        check_side(1);
    endtask

    task automatic read_all(input int d);
        for (int a = 0; a < 4; a++) do_txn(d, 1'b0, 3'(a), 32'h0, 4'h0, 1, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        logic        wr;
        logic [2:0]  a;
        int          reps;
        bit          saw;

        rst = 2'b11; vld = 2'b00; addr = '0; write = 1'b0; wdata = '0; wstrb = '0; event_i = '0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ready_dut%0d", i), 32'(rdy[i]), 32'h0);
            check($sformatf("reset_error_dut%0d", i), 32'(err[i]), 32'h0);
            check($sformatf("reset_rdata_dut%0d", i), rdata[i], 32'h0);
            check_side(i);
        end
        mon_en = 1'b1;

        // Reset contents and zero-wait latency
        read_all(0);
        read_all(1);

        // Byte-strobed SCRATCH write and write counter
        do_txn(0, 1'b1, 3'd1, 32'hA5A5_1234, 4'b0101, 1, 32'h0);
        do_txn(0, 1'b0, 3'd1, 32'h0, 4'h0, 1, 32'h0);
        do_txn(0, 1'b0, 3'd2, 32'h0, 4'h0, 1, 32'h0);

        // Zero-strobe write is a counted-nothing no-op; out-of-range read/write error
        do_txn(0, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'h0, 1, 32'h0);
        do_txn(0, 1'b0, 3'd5, 32'h0, 4'h0, 1, 32'h0);
        do_txn(0, 1'b1, 3'd6, 32'h1234_5678, 4'hF, 1, 32'h0);
        do_txn(0, 1'b0, 3'd2, 32'h0, 4'h0, 1, 32'h0);

        // Wait states: CTRL write with WAIT_CYCLES=3, then an abandoned request
        do_txn(1, 1'b1, 3'd0, 32'h0000_0001, 4'hF, 1, 32'h0);
        @(posedge clk); #1;
        addr = 3'd0; write = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; vld[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        saw = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (rdy[1] === 1'b1) saw = 1'b1;
        end
        check("abort_no_ready", 32'(saw), 32'h0);
        do_txn(1, 1'b0, 3'd0, 32'h0, 4'h0, 1, 32'h0);
        settle_side();

        // Interrupts: event set, set beats same-cycle clear, full clear
        do_txn(0, 1'b1, 3'd0, 32'h0000_0001, 4'hF, 1, 32'h0);
        pulse_event(32'h5);
        settle_side();
        do_txn(0, 1'b1, 3'd3, 32'h0000_0001, 4'hF, 1, 32'h1);
        do_txn(0, 1'b0, 3'd3, 32'h0, 4'h0, 1, 32'h0);
        do_txn(0, 1'b1, 3'd3, 32'h0000_0005, 4'hF, 1, 32'h0);
        settle_side();
        do_txn(0, 1'b0, 3'd3, 32'h0, 4'h0, 1, 32'h0);

        // Write to read-only STATUS
        do_txn(0, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
        do_txn(0, 1'b0, 3'd2, 32'h0, 4'h0, 1, 32'h0);

        // Back-to-back transfers with valid held
        do_txn(0, 1'b1, 3'd1, 32'h0BAD_F00D, 4'hF, 2, 32'h0);
        do_txn(1, 1'b0, 3'd0, 32'h0, 4'h0, 2, 32'h0);

        // Reset in the middle of a waited SCRATCH write
        @(posedge clk); #1;
        addr = 3'd1; write = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; vld[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        vld[1] = 1'b0;
        model_reset(1);
        saw = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (rdy[1] === 1'b1) saw = 1'b1;
        end
        check("reset_abort_no_ready", 32'(saw), 32'h0);
        check_side(1);
        read_all(1);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            reps = int'($urandom_range(1, 2));
            do_txn(d, wr, a, $urandom, 4'($urandom), reps, 32'h0);
            if ($urandom_range(0, 5) == 0) pulse_event($urandom & $urandom & $urandom);
            if (i % 16 == 15) settle_side();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        read_all(0);
        read_all(1);
        settle_side();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb0.size() + sb1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
